alg_seq_div: RTL

//  Sequential restoring divider: the inverse of the Booth multiplier datapath.

---
 rtl/alg_seq_div.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alg_seq_div.sv
// Sequential restoring divider: 2*SIZE-bit dividend / SIZE-bit divisor, one quotient bit per clock.
// Define ALG_DIV_SIGNED_EN for two's complement (truncating) division on the same datapath.
module alg_seq_div #(
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*SIZE-1:0] p,
  input  logic [SIZE-1:0]   x,
  output logic [SIZE-1:0]   q,
  output logic [SIZE-1:0]   r,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              div0
);

  localparam int CW = (SIZE > 2) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [SIZE:0]     rem;
  logic [SIZE-1:0]   dvd;
  logic [SIZE-1:0]   div_r;
  logic [CW-1:0]     cnt;

  logic [2*SIZE-1:0] p_mag;
  logic [SIZE-1:0]   x_mag;
  logic              err_div0;
  logic              err_ovf;

  logic [SIZE:0]     shifted;
  logic [SIZE+1:0]   trial;
  logic              q_bit;
  logic [SIZE:0]     rem_next;
  logic [SIZE-1:0]   dvd_next;
  logic [SIZE-1:0]   rem_lo;

`ifdef ALG_DIV_SIGNED_EN
  localparam logic [SIZE-1:0] HALF = {1'b1, {(SIZE-1){1'b0}}};
  logic              neg_q;
  logic              neg_r;
  logic [SIZE-1:0]   p_lo;
  logic              late_ovf;

  always_comb begin
    p_mag = p[2*SIZE-1] ? -p : p;
    x_mag = x[SIZE-1]   ? -x : x;
  end

  // The magnitude of a negative quotient may reach one more than a positive one.
  always_comb begin
    late_ovf = neg_q ? (dvd_next > HALF) : (dvd_next >= HALF);
  end
`else
  always_comb begin
    p_mag = p;
    x_mag = x;
  end
`endif

  always_comb begin
    err_div0 = (x == '0);
    err_ovf  = !err_div0 && (p_mag[2*SIZE-1:SIZE] >= x_mag);
  end

  // One restoring step; the extra top bit of trial is the borrow of the subtract.
  always_comb begin
    shifted  = {rem[SIZE-1:0], dvd[SIZE-1]};
    trial    = {1'b0, shifted} - {2'b00, div_r};
    q_bit    = ~trial[SIZE+1];
    rem_next = q_bit ? trial[SIZE:0] : shifted;
    dvd_next = {dvd[SIZE-2:0], q_bit};
    rem_lo   = rem_next[SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (err_div0 || err_ovf) ? DONE : CALC;
      CALC:    if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      dvd   <= '0;
      div_r <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      ovf   <= 1'b0;
      div0  <= 1'b0;
`ifdef ALG_DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      p_lo  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (err_div0 || err_ovf) begin
              q    <= '1;
              r    <= p[SIZE-1:0];
              div0 <= err_div0;
              ovf  <= err_ovf;
            end else begin
              rem   <= {1'b0, p_mag[2*SIZE-1:SIZE]};
              dvd   <= p_mag[SIZE-1:0];
              div_r <= x_mag;
              cnt   <= '0;
              ovf   <= 1'b0;
              div0  <= 1'b0;
`ifdef ALG_DIV_SIGNED_EN
              neg_q <= p[2*SIZE-1] ^ x[SIZE-1];
              neg_r <= p[2*SIZE-1];
              p_lo  <= p[SIZE-1:0];
`endif
            end
          end
        end
        CALC: begin
          rem <= rem_next;
          dvd <= dvd_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
`ifdef ALG_DIV_SIGNED_EN
            if (late_ovf) begin
              q   <= '1;
              r   <= p_lo;
              ovf <= 1'b1;
            end else begin
              q <= neg_q ? -dvd_next : dvd_next;
              r <= neg_r ? -rem_lo : rem_lo;
            end
`else
            q <= dvd_next;
            r <= rem_lo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
